// File: rtl/tt_vector_checker.sv
// Purpose : replays a programmed table of stimulus vectors onto a Tiny Tapeout
//           user project and checks its masked responses after LATENCY cycles.
// Latency : vector 0 is driven one cycle after start is accepted. Each response
//           is sampled LATENCY edges after its vector leaves drive_out. done
//           follows start by len+LATENCY+1 cycles.
// Backpressure: none. A start while a run is active is ignored. Table writes
//           are ignored while a run is active.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_stim/       vector table write port (stimulus, expected,
//   wr_exp/wr_mask               compare mask; mask bit 1 = bit checked)
//   len, start                   run length (clamped to DEPTH) and run trigger
//   drive_out -> DUT ui_in       dut_in <- DUT uo_out
//   busy, done, pass             run status; pass is qualified by done
//   err_count, first_err         mismatch total (saturating), first failing index
//
// Optional feature: define VCHK_STOP_ON_ERR_EN to end a run at its first mismatch.

module tt_vector_checker #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_stim,
  input  logic [WIDTH-1:0] wr_exp,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic [CW-1:0]    len,
  input  logic             start,
  output logic [WIDTH-1:0] drive_out,
  input  logic [WIDTH-1:0] dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [AW-1:0]    first_err
);

  // Drain counter runs 0..LATENCY-1.
  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  // Vector table (deliberately not reset).
  logic [WIDTH-1:0] stim_mem [DEPTH];
  logic [WIDTH-1:0] exp_mem  [DEPTH];
  logic [WIDTH-1:0] mask_mem [DEPTH];

  logic             launch;      // start accepted last edge; run begins next edge
  logic [CW-1:0]    len_q;
  logic [AW-1:0]    idx;
  logic [DW-1:0]    dcnt;
  logic [CW-1:0]    err_q;
  logic [AW-1:0]    first_q;

  // Response delay line: (valid, idx) of each vector that has been driven.
  logic [LATENCY-1:0] pv;
  logic [AW-1:0]      pidx [LATENCY];

  logic          idle_like;
  logic          start_ok;
  logic          wr_ok;
  logic [CW-1:0] len_clamped;
  logic          last_vec;
  logic          chk_vld;
  logic [AW-1:0] chk_idx;
  logic          mismatch;
  logic          stop_hit;

  assign idle_like   = (state == IDLE) || (state == DONE);
  assign start_ok    = start && idle_like && !launch;
  assign wr_ok       = wr_en && idle_like;
  assign len_clamped = (len > CW'(DEPTH)) ? CW'(DEPTH) : len;
  assign last_vec    = ((CW'(idx) + CW'(1)) == len_q);

  assign chk_vld  = pv[LATENCY-1];
  assign chk_idx  = pidx[LATENCY-1];
  assign mismatch = chk_vld &&
                    (((dut_in ^ exp_mem[chk_idx]) & mask_mem[chk_idx]) != '0);

`ifdef VCHK_STOP_ON_ERR_EN
  assign stop_hit = mismatch && ((state == RUN) || (state == DRAIN));
`else
  assign stop_hit = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (launch) state_nxt = (len_q == '0) ? DONE : RUN;
      RUN:        if (last_vec) state_nxt = DRAIN;
      DRAIN:      if (dcnt == DW'(LATENCY - 1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (stop_hit) state_nxt = DONE;
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  // done stays low during the launch cycle so a restart clears it immediately.
  always_comb begin
    drive_out = (state == RUN) ? stim_mem[idx] : '0;
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE) && !launch;
    pass      = done && (err_q == '0);
    err_count = err_q;
    first_err = first_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      launch  <= 1'b0;
      len_q   <= '0;
      idx     <= '0;
      dcnt    <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state  <= state_nxt;
      launch <= start_ok;
      idx    <= (state == RUN) ? idx + AW'(1) : '0;
      dcnt   <= (state == DRAIN) ? dcnt + DW'(1) : '0;
      if (start_ok) begin
        len_q   <= len_clamped;
        err_q   <= '0;
        first_q <= '0;
      end else if (mismatch) begin
        if (err_q != '1) err_q <= err_q + CW'(1);
        if (err_q == '0) first_q <= chk_idx;
      end
    end
  end

  // Every vector driven this cycle enters the delay line at the closing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LATENCY; i++) pidx[i] <= '0;
    end else if (stop_hit) begin
      pv <= '0;   // responses still in flight are discarded
    end else begin
      pv[0]   <= (state == RUN);
      pidx[0] <= idx;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
    end
  end

  // Table write port; the entry is readable from the next cycle, so a write
  // alongside start is seen by that run.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      stim_mem[wr_addr] <= wr_stim;
      exp_mem[wr_addr]  <= wr_exp;
      mask_mem[wr_addr] <= wr_mask;
    end
  end

endmodule

// File: tb/tb_tt_vector_checker.sv
// Bench for tt_vector_checker: the DUT stand-in is a one-cycle register with an
// optional per-value corruption table; a run-level model predicts every cycle.
module tb_tt_vector_checker;
  localparam int WIDTH = 8, DEPTH = 16, LATENCY = 1, AW = 4, CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [WIDTH-1:0] wr_stim = '0, wr_exp = '0, wr_mask = '0;
  logic [CW-1:0] len = '0;
  logic start = 1'b0;
  logic [WIDTH-1:0] drive_out, dut_in;
  logic busy, done, pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err;

  tt_vector_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
    .wr_exp(wr_exp), .wr_mask(wr_mask), .len(len), .start(start),
    .drive_out(drive_out), .dut_in(dut_in), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err(first_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // User-project stand-in: uo_out = f(ui_in) registered once.
  logic [7:0] xtab [256];
  function automatic logic [7:0] dut_f(input logic [7:0] v);
    return v ^ xtab[v];
  endfunction
  logic [7:0] uo_q = '0;
  always @(posedge clk) uo_q <= dut_f(drive_out);
  assign dut_in = uo_q;

  int npass = 0, ntot = 0;
  task automatic chk(input string nm, input int a, input int e);
    ntot++;
    if (a == e) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, a, e, $time);
  endtask

  // Bench copy of the table as it should be after accepted writes.
  logic [7:0] cp_stim [DEPTH], cp_exp [DEPTH], cp_mask [DEPTH];

  // Run model: what the run must do, from length, table and DUT function.
  bit m_active = 1'b0;
  int t0 = 0, m_n = 0, m_end = 0, m_errs = 0, m_first = 0;
  logic [7:0] m_stim [DEPTH];

  task automatic model_start(input int l);
    m_n = (l > DEPTH) ? DEPTH : l;
    m_errs = 0; m_first = 0;
    for (int k = 0; k < DEPTH; k++) m_stim[k] = cp_stim[k];
    for (int k = 0; k < m_n; k++)
      if (((dut_f(cp_stim[k]) ^ cp_exp[k]) & cp_mask[k]) != 8'h00) begin
        if (m_errs == 0) m_first = k;
        m_errs++;
      end
    m_end = (m_n == 0) ? 1 : m_n + LATENCY + 1;
`ifdef VCHK_STOP_ON_ERR_EN
    if (m_errs > 0) begin
      m_errs = 1;
      if (m_first + 2 + LATENCY < m_end) m_end = m_first + 2 + LATENCY;
    end
`endif
  endtask

  // Cycle-by-cycle compare against the model (c = edges since start was sampled).
  always @(negedge clk) begin : cmp
    int c;
    if (m_active) begin
      c = cyc - t0;
      if (c == 0) begin
        chk("busy", busy, 0); chk("done", done, 0); chk("drive_out", drive_out, 0);
      end else if (c < m_end) begin
        chk("busy", busy, m_n > 0); chk("done", done, 0);
        chk("drive_out", drive_out, (c <= m_n) ? int'(m_stim[c-1]) : 0);
      end else begin
        chk("busy", busy, 0); chk("done", done, 1); chk("drive_out", drive_out, 0);
        chk("pass", pass, m_errs == 0);
        chk("err_count", err_count, m_errs);
        if (m_errs > 0) chk("first_err", first_err, m_first);
      end
    end
  end

  task automatic wr(input int a, input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_stim = s; wr_exp = e; wr_mask = m;
    @(negedge clk);
    wr_en = 1'b0;
    cp_stim[a] = s; cp_exp[a] = e; cp_mask[a] = m;
  endtask

  // act: 0 none, 1 write entry 2 at cycle act_c, 2 restart at act_c,
  //      4 write entry 0 = 0x55 in the same cycle as start.
  task automatic do_run(input int l, input int act, input int act_c,
                        output int done_c, output int ndrv,
                        output logic [7:0] d1, output logic [7:0] d3);
    int c;
    @(negedge clk);
    len = CW'(l); start = 1'b1;
    if (act == 4) begin
      wr_en = 1'b1; wr_addr = '0; wr_stim = 8'h55; wr_exp = 8'h55; wr_mask = 8'hFF;
      cp_stim[0] = 8'h55; cp_exp[0] = 8'h55; cp_mask[0] = 8'hFF;
    end
    @(posedge clk);
    #1;
    start = 1'b0; wr_en = 1'b0;
    t0 = cyc; model_start(l); m_active = 1'b1;
    done_c = -1; ndrv = 0; d1 = '0; d3 = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      c = cyc - t0;
      if (c == 1) d1 = drive_out;
      if (c == 3) d3 = drive_out;
      if (drive_out != 8'h00) ndrv++;
      if (c == act_c + 1) begin wr_en = 1'b0; start = 1'b0; len = CW'(l); end
      if (c == act_c && act == 1) begin
        wr_en = 1'b1; wr_addr = AW'(2); wr_stim = 8'hEE; wr_exp = 8'hEE; wr_mask = 8'hFF;
      end
      if (c == act_c && act == 2) begin start = 1'b1; len = CW'(3); end
      if (done && c > 0) begin done_c = c; break; end
    end
    wr_en = 1'b0; start = 1'b0;
    chk("done_seen", done_c >= 0, 1);
  endtask

  int dc, nd;
  logic [7:0] d1, d3;

  initial begin
    for (int i = 0; i < 256; i++) xtab[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_drive", drive_out, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_pass", pass, 0); chk("rst_err", err_count, 0); chk("rst_first", first_err, 0);
    rst = 1'b0;

    for (int k = 0; k < DEPTH; k++) wr(k, 8'(k + 1), 8'(k + 1), 8'hFF);

    // All-pass run
    do_run(16, 0, -5, dc, nd, d1, d3);
    chk("allpass_done_cycle", dc, 18); chk("allpass_pass", pass, 1);
    chk("allpass_err", err_count, 0); chk("allpass_ndrv", nd, 16);

    // Masked mismatch on entry 5: DUT returns 0xA4 for exp 0xA5
    xtab[8'h06] = 8'hA2;
    wr(5, 8'h06, 8'hA5, 8'hFE);
    do_run(16, 0, -5, dc, nd, d1, d3);
    chk("mask_fe_pass", pass, 1);
    wr(5, 8'h06, 8'hA5, 8'hFF);
    do_run(16, 0, -5, dc, nd, d1, d3);
    chk("mask_ff_pass", pass, 0); chk("mask_ff_err", err_count, 1);
    chk("mask_ff_first", first_err, 5);
    xtab[8'h06] = 8'h00;
    wr(5, 8'h06, 8'h06, 8'hFF);

    // Entries 3, 7, 9 corrupted
    xtab[8'h04] = 8'h01; xtab[8'h08] = 8'h01; xtab[8'h0A] = 8'h01;
    do_run(16, 0, -5, dc, nd, d1, d3);
`ifdef VCHK_STOP_ON_ERR_EN
    chk("multi_err", err_count, 1); chk("multi_done_cycle", dc, 6);
    chk("multi_drive_after", drive_out, 0);
`else
    chk("multi_err", err_count, 3); chk("multi_done_cycle", dc, 18);
`endif
    chk("multi_first", first_err, 3);
    xtab[8'h04] = 8'h00; xtab[8'h08] = 8'h00; xtab[8'h0A] = 8'h00;

    // Edge lengths
    do_run(0, 0, -5, dc, nd, d1, d3);
    chk("len0_done_cycle", dc, 1); chk("len0_pass", pass, 1); chk("len0_ndrv", nd, 0);
    do_run(20, 0, -5, dc, nd, d1, d3);
    chk("len20_ndrv", nd, 16); chk("len20_done_cycle", dc, 18);

    // Write during RUN is ignored; rerun still drives the old entry 2
    do_run(16, 1, 3, dc, nd, d1, d3);
    do_run(16, 0, -5, dc, nd, d1, d3);
    chk("wr_in_run_d3", d3, 8'h03); chk("wr_in_run_pass", pass, 1);

    // Start during RUN is ignored
    do_run(16, 2, 5, dc, nd, d1, d3);
    chk("restart_done_cycle", dc, 18); chk("restart_ndrv", nd, 16);

    // Write and start together: new entry 0 is driven first
    do_run(2, 4, -5, dc, nd, d1, d3);
    chk("wr_start_d1", d1, 8'h55); chk("wr_start_done_cycle", dc, 4);

    // Reset mid-run with one error already counted
    xtab[8'h55] = 8'h80;
    @(negedge clk);
    len = CW'(16); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; t0 = cyc; model_start(16); m_active = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1); chk("mid_err", err_count, 1);
    #2;
    m_active = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_drive", drive_out, 0); chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0); chk("rst_mid_err", err_count, 0);
    chk("rst_mid_pass", pass, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0); chk("post_rst_done", done, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
